// File: rtl/mem_pkg.sv
// Shared constants for mem_responder: FSM state encoding, op encoding, default sizes.
package mem_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 512;

  // FSM states, kept as plain 2-bit constants for legacy tool flows
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  // Latched operation
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word RAM. Read data is registered and only updated on
// a read enable, so it holds across writes and idle cycles.
module ram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,    // clears rdata only, never the array
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rzero_i,  // return zero instead of array data on this read
  input  logic [IdxW-1:0]   idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Registered read port, held between reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts level Read/Write requests from the control unit,
// inserts WAIT_CYCLES wait states, performs one RAM access per request level and
// pulses MemDone. Optional address range check under `MEM_RANGE_CHECK_EN`.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemDone,
  output logic              Busy,
  output logic              AccessErr
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = (WAIT_CYCLES > 0) ? CntW'(WAIT_CYCLES - 1) : '0;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_q, op_d;
  logic              oor_q, oor_d;
  logic              err_q, err_d;

  logic              req;
  logic              addr_oor;
  logic              commit;
  logic [IdxW-1:0]   cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_op;
  logic              cur_oor;
  logic              ram_we, ram_re;

  assign req = Read | Write;

`ifdef MEM_RANGE_CHECK_EN
  assign addr_oor = (Address >= ADDR_W'(DEPTH));
`else
  assign addr_oor = 1'b0;
`endif

  // With zero wait states the access happens at the acceptance edge, so take live inputs
  always_comb begin
    if (state_q == StIdle) begin
      cur_idx   = Address[IdxW-1:0];
      cur_wdata = WriteData;
      cur_op    = Write ? OP_WR : OP_RD;
      cur_oor   = addr_oor;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_op    = op_q;
      cur_oor   = oor_q;
    end
  end

  // FSM next state, request latching and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    oor_d   = oor_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d   = Address[IdxW-1:0];
          wdata_d = WriteData;
          op_d    = Write ? OP_WR : OP_RD;
          oor_d   = addr_oor;
          err_d   = 1'b0;
          cnt_d   = CntLoad;
          if (WAIT_CYCLES == 0) begin
            state_d = StDone;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = req ? StRelease : StIdle;
      end
      StRelease: begin
        // Hold off until the control unit drops its request level
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      err_d = cur_oor;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
    end
  end

  // A reset on the commit edge drops the pending access
  assign ram_we = commit && (cur_op == OP_WR) && !cur_oor && !Reset;
  assign ram_re = commit && (cur_op == OP_RD) && !Reset;

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .rzero_i (cur_oor),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (ReadData)
  );

  assign MemDone   = (state_q == StDone);
  assign Busy      = (state_q == StWait) || (state_q == StDone);
  assign AccessErr = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build (2 wait states) plus a
// zero-wait-state instance.
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Read = 1'b0, Write = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        MemDone, Busy, AccessErr;

  logic        Read0 = 1'b0, Write0 = 1'b0;
  logic [31:0] Address0 = '0, WriteData0 = '0;
  logic [31:0] ReadData0;
  logic        MemDone0, Busy0, AccessErr0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(2)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Read      (Read),
    .Write     (Write),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .MemDone   (MemDone),
    .Busy      (Busy),
    .AccessErr (AccessErr)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(0)) dut0 (
    .Clock     (Clock),
    .Reset     (Reset),
    .Read      (Read0),
    .Write     (Write0),
    .Address   (Address0),
    .WriteData (WriteData0),
    .ReadData  (ReadData0),
    .MemDone   (MemDone0),
    .Busy      (Busy0),
    .AccessErr (AccessErr0)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold a request for 'hold' cycles, scramble address/data after acceptance,
  // then drop it and let the FSM settle back to idle.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold,
                        output int dones, output int busys, output int done_at,
                        output logic [31:0] rd_at_done, output logic err_at_done);
    Read = rd; Write = wr; Address = addr; WriteData = data;
    dones = 0; busys = 0; done_at = -1; rd_at_done = 'x; err_at_done = 1'bx;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (i == 1) begin
        Address   = 32'h3;
        WriteData = 32'h0;
      end
      if (MemDone) begin
        dones++;
        done_at     = i;
        rd_at_done  = ReadData;
        err_at_done = AccessErr;
      end
      if (Busy) busys++;
    end
    Read = 1'b0; Write = 1'b0;
    tick();
    tick();
  endtask

  int          d, b, at;
  logic [31:0] rdv;
  logic        erv;

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_memdone", {31'b0, MemDone}, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_accesserr", {31'b0, AccessErr}, 32'h0);

    // Write 0x5 held 6 cycles: one pulse, 3 cycles after acceptance, Busy for 3
    run_op(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 6, d, b, at, rdv, erv);
    chk("wr5_dones", d, 1);
    chk("wr5_done_at", at, 3);
    chk("wr5_busy_cycles", b, 3);
    chk("wr5_readdata_untouched", ReadData, 32'h0);

    // Read 0x5 held 10 cycles: exactly one access, data in the MemDone cycle
    run_op(1'b1, 1'b0, 32'h5, 32'h0, 10, d, b, at, rdv, erv);
    chk("rd5_dones", d, 1);
    chk("rd5_done_at", at, 3);
    chk("rd5_busy_cycles", b, 3);
    chk("rd5_data", rdv, 32'hDEADBEEF);
    chk("rd5_hold", ReadData, 32'hDEADBEEF);

    // Read and Write together: write wins, ReadData keeps last read value
    run_op(1'b1, 1'b1, 32'h7, 32'h12345678, 5, d, b, at, rdv, erv);
    chk("rw7_dones", d, 1);
    chk("rw7_readdata_kept", ReadData, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 32'h7, 32'h0, 4, d, b, at, rdv, erv);
    chk("rd7_data", rdv, 32'h12345678);

    // Aliasing: 0x205 maps onto word 5 in the default build
    run_op(1'b1, 1'b0, 32'h205, 32'h0, 4, d, b, at, rdv, erv);
`ifdef MEM_RANGE_CHECK_EN
    chk("rd205_data", rdv, 32'h0);
    chk("rd205_err", {31'b0, erv}, 32'h1);
`else
    chk("rd205_data", rdv, 32'hDEADBEEF);
    chk("rd205_err", {31'b0, erv}, 32'h0);
`endif

    // Reset during WAIT drops the pending write
    run_op(1'b0, 1'b1, 32'h9, 32'hA5A5A5A5, 4, d, b, at, rdv, erv);
    Write = 1'b1; Address = 32'h9; WriteData = 32'h11111111;
    tick();
    chk("midrst_busy_before", {31'b0, Busy}, 32'h1);
    tick();
    Reset = 1'b1; Write = 1'b0;
    tick();
    chk("midrst_busy", {31'b0, Busy}, 32'h0);
    chk("midrst_memdone", {31'b0, MemDone}, 32'h0);
    chk("midrst_readdata", ReadData, 32'h0);
    chk("midrst_err", {31'b0, AccessErr}, 32'h0);
    Reset = 1'b0;
    tick();
    run_op(1'b1, 1'b0, 32'h9, 32'h0, 4, d, b, at, rdv, erv);
    chk("rd9_prior", rdv, 32'hA5A5A5A5);

    // Out-of-range write of 0x200
    run_op(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4, d, b, at, rdv, erv);
    run_op(1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 4, d, b, at, rdv, erv);
    chk("wr200_dones", d, 1);
    chk("wr200_done_at", at, 3);
    run_op(1'b1, 1'b0, 32'h0, 32'h0, 4, d, b, at, rdv, erv);
    chk("rd0_err_cleared", {31'b0, erv}, 32'h0);
`ifdef MEM_RANGE_CHECK_EN
    chk("rd0_after_oor_wr", rdv, 32'h0BADF00D);
`else
    chk("rd0_after_alias_wr", rdv, 32'hFFFFFFFF);
`endif

    // Zero wait states: MemDone in the cycle right after acceptance
    Write0 = 1'b1; Address0 = 32'h5; WriteData0 = 32'hCAFEF00D;
    tick();
    chk("w0_wr_done", {31'b0, MemDone0}, 32'h1);
    chk("w0_wr_busy", {31'b0, Busy0}, 32'h1);
    Write0 = 1'b0;
    tick();
    chk("w0_wr_idle", {31'b0, MemDone0}, 32'h0);
    Read0 = 1'b1;
    tick();
    chk("w0_rd_done", {31'b0, MemDone0}, 32'h1);
    chk("w0_rd_data", ReadData0, 32'hCAFEF00D);
    tick();
    chk("w0_rd_release", {31'b0, MemDone0}, 32'h0);
    chk("w0_rd_release_busy", {31'b0, Busy0}, 32'h0);
    Read0 = 1'b0;
    tick();
    tick();
    chk("w0_idle_done", {31'b0, MemDone0}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
